// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Optional perf counters are enabled with HAZ_PERF_CNT_EN.
package pipe_hazard_ctrl_pkg;

    typedef enum logic {
        StIdle,
        StBrWait
    } br_state_e;

    localparam int unsigned FwdSelW = 3;
    localparam logic [FwdSelW-1:0] FWD_RF = 3'd0;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle.
// master = pipeline side, slave = hazard controller.
interface pipe_hazard_ctrl_if #(
    parameter int unsigned FWD_STAGES = 2,
    parameter int unsigned REG_AW     = 5
);
    logic [REG_AW-1:0]            id_rs;
    logic [REG_AW-1:0]            id_rt;
    logic                         id_use_rs;
    logic                         id_use_rt;
    logic                         id_is_mul;
    logic [REG_AW-1:0]            id_rd;
    logic                         id_is_branch;
    logic [FWD_STAGES-1:0]        st_wreg;
    logic [FWD_STAGES*REG_AW-1:0] st_rn;
    logic                         ex_m2reg;
    logic                         br_resolved;
    logic                         br_taken;
    logic [2:0]                   fwd_a;
    logic [2:0]                   fwd_b;
    logic                         stall;
    logic                         we_pc_ir;
    logic                         flush_id;
    logic                         pc_taken;
    logic                         mul_busy;
    logic [31:0]                  stall_cycles;
    logic [31:0]                  bubble_cycles;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, id_is_mul, id_rd, id_is_branch,
               st_wreg, st_rn, ex_m2reg, br_resolved, br_taken,
        input  fwd_a, fwd_b, stall, we_pc_ir, flush_id, pc_taken, mul_busy,
               stall_cycles, bubble_cycles
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, id_is_mul, id_rd, id_is_branch,
               st_wreg, st_rn, ex_m2reg, br_resolved, br_taken,
        output fwd_a, fwd_b, stall, we_pc_ir, flush_id, pc_taken, mul_busy,
               stall_cycles, bubble_cycles
    );
endinterface

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// Forwarding source select for one ID operand: nearest writing stage wins,
// register 0 is never forwarded.
module fwd_sel
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned FWD_STAGES = 2,
    parameter int unsigned REG_AW     = 5
) (
    input  logic [REG_AW-1:0]            rs_i,
    input  logic                         use_i,
    input  logic [FWD_STAGES-1:0]        st_wreg_i,
    input  logic [FWD_STAGES*REG_AW-1:0] st_rn_i,
    output logic [FwdSelW-1:0]           sel_o
);

    always_comb begin
        sel_o = FWD_RF;
        if (use_i && (rs_i != '0)) begin
            // Walk from the farthest stage so the nearest match is assigned last.
            for (int k = FWD_STAGES - 1; k >= 0; k--) begin
                if (st_wreg_i[k] && (st_rn_i[k*REG_AW +: REG_AW] == rs_i)) begin
                    sel_o = FwdSelW'(k + 1);
                end
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: forwarding, load-use/multiply stalls, branch wait FSM.
// Define HAZ_PERF_CNT_EN to build the saturating stall/bubble counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned FWD_STAGES = 2,
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned MUL_LAT    = 3
) (
    input logic               clock,
    input logic               reset,
    pipe_hazard_ctrl_if.slave bus
);

    localparam int unsigned CntW = 3;
    localparam logic [CntW-1:0] MulInit = CntW'(MUL_LAT - 1);

    logic [CntW-1:0]   mul_cnt_q, mul_cnt_d;
    logic [REG_AW-1:0] mul_rd_q, mul_rd_d;
    br_state_e         state_q, state_d;

    logic rs_live, rt_live, load_use, mul_busy, mul_hazard, stall;

    fwd_sel #(.FWD_STAGES(FWD_STAGES), .REG_AW(REG_AW)) u_fwd_a (
        .rs_i      (bus.id_rs),
        .use_i     (bus.id_use_rs),
        .st_wreg_i (bus.st_wreg),
        .st_rn_i   (bus.st_rn),
        .sel_o     (bus.fwd_a)
    );

    fwd_sel #(.FWD_STAGES(FWD_STAGES), .REG_AW(REG_AW)) u_fwd_b (
        .rs_i      (bus.id_rt),
        .use_i     (bus.id_use_rt),
        .st_wreg_i (bus.st_wreg),
        .st_rn_i   (bus.st_rn),
        .sel_o     (bus.fwd_b)
    );

    always_comb begin
        rs_live    = bus.id_use_rs && (bus.id_rs != '0);
        rt_live    = bus.id_use_rt && (bus.id_rt != '0);
        load_use   = bus.ex_m2reg &&
                     ((rs_live && (bus.st_rn[REG_AW-1:0] == bus.id_rs)) ||
                      (rt_live && (bus.st_rn[REG_AW-1:0] == bus.id_rt)));
        mul_busy   = (mul_cnt_q != '0);
        mul_hazard = mul_busy &&
                     (bus.id_is_mul ||
                      (rs_live && (bus.id_rs == mul_rd_q)) ||
                      (rt_live && (bus.id_rt == mul_rd_q)));
        stall      = load_use || mul_hazard;
    end

    // Multiply scoreboard: a stalled multiply does not issue.
    always_comb begin
        mul_cnt_d = mul_cnt_q;
        mul_rd_d  = mul_rd_q;
        if (bus.id_is_mul && !stall) begin
            mul_cnt_d = MulInit;
            mul_rd_d  = bus.id_rd;
        end else if (mul_busy) begin
            mul_cnt_d = mul_cnt_q - 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (bus.id_is_branch && !stall) state_d = StBrWait;
            StBrWait: if (bus.br_resolved) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mul_cnt_q <= '0;
            mul_rd_q  <= '0;
            state_q   <= StIdle;
        end else begin
            mul_cnt_q <= mul_cnt_d;
            mul_rd_q  <= mul_rd_d;
            state_q   <= state_d;
        end
    end

    assign bus.stall    = stall;
    assign bus.mul_busy = mul_busy;
    assign bus.we_pc_ir = !stall && (state_q == StIdle);
    assign bus.flush_id = (state_q == StBrWait);
    assign bus.pc_taken = (state_q == StBrWait) && bus.br_taken && bus.br_resolved;

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d, bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
        if ((state_q == StBrWait) && (bubble_cnt_q != '1)) bubble_cnt_d = bubble_cnt_q + 32'd1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bus.stall_cycles  = stall_cnt_q;
    assign bus.bubble_cycles = bubble_cnt_q;
`else
    assign bus.stall_cycles  = '0;
    assign bus.bubble_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (default parameters).
module tb_pipe_hazard_ctrl;
    import pipe_hazard_ctrl_pkg::*;

    localparam int unsigned FWD_STAGES = 2;
    localparam int unsigned REG_AW     = 5;
    localparam int unsigned MUL_LAT    = 3;

`ifdef HAZ_PERF_CNT_EN
    localparam logic [31:0] ExpStallCnt  = 32'd6;
    localparam logic [31:0] ExpBubbleCnt = 32'd3;
`else
    localparam logic [31:0] ExpStallCnt  = 32'd0;
    localparam logic [31:0] ExpBubbleCnt = 32'd0;
`endif

    typedef struct {
        string      tag;
        logic [2:0] fa;
        logic [2:0] fb;
        logic       st;
        logic       we;
        logic       fl;
        logic       pc;
        logic       mb;
    } exp_t;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_errors;
    exp_t sb_q[$];

    pipe_hazard_ctrl_if #(.FWD_STAGES(FWD_STAGES), .REG_AW(REG_AW)) bus ();

    pipe_hazard_ctrl #(
        .FWD_STAGES (FWD_STAGES),
        .REG_AW     (REG_AW),
        .MUL_LAT    (MUL_LAT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input string tag, input int fa, input int fb, input bit st,
                                input bit we, input bit fl, input bit pc, input bit mb);
        exp_t e;
        e.tag = tag;
        e.fa  = 3'(fa);
        e.fb  = 3'(fb);
        e.st  = st;
        e.we  = we;
        e.fl  = fl;
        e.pc  = pc;
        e.mb  = mb;
        return e;
    endfunction

    task automatic compare_head();
        exp_t e;
        if (sb_q.size() == 0) begin
            check_val("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = sb_q.pop_front();
        check_val({e.tag, ".fwd_a"}, 32'(bus.fwd_a), 32'(e.fa));
        check_val({e.tag, ".fwd_b"}, 32'(bus.fwd_b), 32'(e.fb));
        check_val({e.tag, ".stall"}, 32'(bus.stall), 32'(e.st));
        check_val({e.tag, ".we_pc_ir"}, 32'(bus.we_pc_ir), 32'(e.we));
        check_val({e.tag, ".flush_id"}, 32'(bus.flush_id), 32'(e.fl));
        check_val({e.tag, ".pc_taken"}, 32'(bus.pc_taken), 32'(e.pc));
        check_val({e.tag, ".mul_busy"}, 32'(bus.mul_busy), 32'(e.mb));
    endtask

    // Inputs for this cycle are already driven; push expectation, compare mid-cycle, advance.
    task automatic cyc(input exp_t e);
        sb_q.push_back(e);
        @(negedge clock);
        compare_head();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        bus.id_rs        = '0;
        bus.id_rt        = '0;
        bus.id_use_rs    = 1'b0;
        bus.id_use_rt    = 1'b0;
        bus.id_is_mul    = 1'b0;
        bus.id_rd        = '0;
        bus.id_is_branch = 1'b0;
        bus.st_wreg      = '0;
        bus.st_rn        = '0;
        bus.ex_m2reg     = 1'b0;
        bus.br_resolved  = 1'b0;
        bus.br_taken     = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        clear_inputs();
        #12;
        sb_q.push_back(mk("reset", 0, 0, 0, 1, 0, 0, 0));
        compare_head();
        check_val("reset.stall_cycles", bus.stall_cycles, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Forwarding: nearest stage wins, MEM-only match, register 0 / unused source.
        bus.st_wreg = 2'b11; bus.st_rn = {5'd8, 5'd8}; bus.id_rs = 5'd8; bus.id_use_rs = 1'b1;
        cyc(mk("fwd_nearest", 1, 0, 0, 1, 0, 0, 0));
        bus.st_wreg = 2'b10; bus.st_rn = {5'd8, 5'd3}; bus.id_rt = 5'd3; bus.id_use_rt = 1'b1;
        cyc(mk("fwd_mem_only", 2, 0, 0, 1, 0, 0, 0));
        bus.st_wreg = 2'b11; bus.st_rn = {5'd0, 5'd0}; bus.id_rs = 5'd0; bus.id_rt = 5'd0;
        cyc(mk("fwd_r0", 0, 0, 0, 1, 0, 0, 0));
        bus.st_rn = {5'd12, 5'd12}; bus.id_rs = 5'd12; bus.id_use_rs = 1'b0;
        bus.id_rt = 5'd12; bus.id_use_rt = 1'b0;
        cyc(mk("fwd_unused", 0, 0, 0, 1, 0, 0, 0));

        // Load-use on rt, then load in MEM forwards from stage 2.
        clear_inputs();
        bus.ex_m2reg = 1'b1; bus.st_wreg = 2'b01; bus.st_rn = {5'd0, 5'd5};
        bus.id_rt = 5'd5; bus.id_use_rt = 1'b1;
        cyc(mk("load_use", 0, 1, 1, 0, 0, 0, 0));
        bus.ex_m2reg = 1'b0; bus.st_wreg = 2'b10; bus.st_rn = {5'd5, 5'd0};
        cyc(mk("load_in_mem", 0, 2, 0, 1, 0, 0, 0));
        bus.ex_m2reg = 1'b1; bus.st_wreg = 2'b01; bus.st_rn = '0; bus.id_rt = 5'd0;
        cyc(mk("load_r0", 0, 0, 0, 1, 0, 0, 0));

        // Multiply to r9 followed by a reader of r9: two stall cycles.
        clear_inputs();
        bus.id_is_mul = 1'b1; bus.id_rd = 5'd9;
        cyc(mk("mul9_issue", 0, 0, 0, 1, 0, 0, 0));
        bus.id_is_mul = 1'b0; bus.id_rs = 5'd9; bus.id_use_rs = 1'b1;
        cyc(mk("mul9_use1", 0, 0, 1, 0, 0, 0, 1));
        cyc(mk("mul9_use2", 0, 0, 1, 0, 0, 0, 1));
        cyc(mk("mul9_done", 0, 0, 0, 1, 0, 0, 0));

        // Back-to-back multiplies: second waits, issues once busy drops, rd re-latched.
        clear_inputs();
        bus.id_is_mul = 1'b1; bus.id_rd = 5'd4;
        cyc(mk("mulA_issue", 0, 0, 0, 1, 0, 0, 0));
        bus.id_rd = 5'd6;
        cyc(mk("mulB_wait1", 0, 0, 1, 0, 0, 0, 1));
        cyc(mk("mulB_wait2", 0, 0, 1, 0, 0, 0, 1));
        cyc(mk("mulB_issue", 0, 0, 0, 1, 0, 0, 0));
        bus.id_is_mul = 1'b0; bus.id_rs = 5'd4; bus.id_use_rs = 1'b1;
        cyc(mk("mulB_old_rd", 0, 0, 0, 1, 0, 0, 1));
        bus.id_rs = 5'd6;
        cyc(mk("mulB_new_rd", 0, 0, 1, 0, 0, 0, 1));
        cyc(mk("mulB_done", 0, 0, 0, 1, 0, 0, 0));

        // Branch waits three cycles and resolves taken.
        clear_inputs();
        bus.id_is_branch = 1'b1;
        cyc(mk("br_issue", 0, 0, 0, 1, 0, 0, 0));
        bus.id_is_branch = 1'b0;
        cyc(mk("br_wait1", 0, 0, 0, 0, 1, 0, 0));
        bus.br_taken = 1'b1;
        cyc(mk("br_wait2", 0, 0, 0, 0, 1, 0, 0));
        bus.br_resolved = 1'b1;
        cyc(mk("br_resolve", 0, 0, 0, 0, 1, 1, 0));
        bus.br_resolved = 1'b0; bus.br_taken = 1'b0;
        check_val("stall_cycles", bus.stall_cycles, ExpStallCnt);
        check_val("bubble_cycles", bus.bubble_cycles, ExpBubbleCnt);
        cyc(mk("br_idle", 0, 0, 0, 1, 0, 0, 0));

        // Stray resolution while idle is ignored.
        bus.br_resolved = 1'b1; bus.br_taken = 1'b1;
        cyc(mk("br_stray", 0, 0, 0, 1, 0, 0, 0));
        clear_inputs();
        cyc(mk("br_stray_after", 0, 0, 0, 1, 0, 0, 0));

        // Branch held behind a load-use stall enters the wait only after the stall.
        bus.ex_m2reg = 1'b1; bus.st_wreg = 2'b01; bus.st_rn = {5'd0, 5'd5};
        bus.id_rs = 5'd5; bus.id_use_rs = 1'b1; bus.id_is_branch = 1'b1;
        cyc(mk("br_behind_stall", 1, 0, 1, 0, 0, 0, 0));
        bus.ex_m2reg = 1'b0; bus.st_wreg = 2'b00;
        cyc(mk("br_after_stall", 0, 0, 0, 1, 0, 0, 0));
        clear_inputs();
        bus.id_is_mul = 1'b1; bus.id_rd = 5'd7;
        cyc(mk("br_wait_mul", 0, 0, 0, 0, 1, 0, 0));
        bus.id_is_mul = 1'b0;
        cyc(mk("br_wait_busy", 0, 0, 0, 0, 1, 0, 1));

        // Asynchronous reset mid-branch-wait and mid-multiply.
        bus.id_rs = 5'd0; bus.id_use_rs = 1'b1; bus.st_wreg = 2'b01; bus.st_rn = '0;
        reset = 1'b1;
        #1;
        sb_q.push_back(mk("async_reset", 0, 0, 0, 1, 0, 0, 0));
        compare_head();
        check_val("async_reset.stall_cycles", bus.stall_cycles, 32'd0);
        check_val("async_reset.bubble_cycles", bus.bubble_cycles, 32'd0);
        #2;
        reset = 1'b0;
        clear_inputs();
        cyc(mk("post_reset", 0, 0, 0, 1, 0, 0, 0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter FWD_STAGES, default 2: number of downstream stages (EX, MEM, WB, ...) checked for forwarding, legal range 1..4.
REQ-002 Parameter REG_AW, default 5: register-number width.
REQ-003 Parameter MUL_LAT, default 3: multiply execution latency in cycles, legal range 1..8.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset; ports are named clock and reset.
REQ-005 Ports (name, direction, width, meaning):
- clock  in  1  rising-edge clock
- reset  in  1  async active-high reset
- id_rs, id_rt  in  REG_AW  ID source registers
- id_use_rs, id_use_rt  in  1  source actually read
- id_is_mul  in  1  ID holds a multi-cycle multiply
- id_rd  in  REG_AW  ID destination register
- id_is_branch  in  1  ID holds beq/bne
- st_wreg  in  FWD_STAGES  per-stage write enable; bit 0 = EX
- st_rn  in  FWD_STAGES*REG_AW  per-stage destination; slice 0 = EX
- ex_m2reg  in  1  EX holds a load
- br_resolved  in  1  branch outcome valid in EX
- br_taken  in  1  outcome
- fwd_a, fwd_b  out  3  0 = register file, k = stage k-1
- stall  out  1  hold PC/IR, bubble into EX
- we_pc_ir  out  1  PC/IR write enable
- flush_id  out  1  zero IR next edge
- pc_taken  out  1  select branch target
- mul_busy  out  1  multiply in flight
- stall_cycles  out  32  performance count
- bubble_cycles  out  32  performance count

Function
REQ-006 fwd_a SHALL equal k+1 for the lowest k with st_wreg[k], st_rn[k]==id_rs, id_use_rs and id_rs!=0; otherwise 0. fwd_b is the same for rt. Combinational.
REQ-007 Register 0 SHALL never be forwarded or cause a stall.
REQ-008 Load-use: ex_m2reg with st_rn[0] matching a used nonzero source SHALL assert stall for exactly one cycle.
REQ-009 An issuing multiply (id_is_mul, stall low) SHALL load mul_cnt with MUL_LAT-1 and latch id_rd; mul_busy = (mul_cnt != 0).
REQ-010 While mul_busy, mul_cnt SHALL decrement by 1 per cycle, saturating at 0.
REQ-011 While mul_busy, stall SHALL be asserted if a used nonzero source equals the latched rd, or if id_is_mul is high.
REQ-012 MUL_LAT = 1: mul_busy never asserts.
REQ-013 Branch FSM states are IDLE and BR_WAIT. IDLE -> BR_WAIT when id_is_branch and stall is low. BR_WAIT -> IDLE on br_resolved.
REQ-014 In BR_WAIT: we_pc_ir = 0 and flush_id = 1. pc_taken = br_taken & br_resolved, combinational.
REQ-015 we_pc_ir = ~stall & (state==IDLE).
REQ-016 Priority: stall over branch entry. A branch waiting behind a load-use or multiply stall SHALL NOT enter BR_WAIT until stall drops.
REQ-017 br_resolved while IDLE SHALL be ignored.

Reset
REQ-018 On reset: state = IDLE, mul_cnt = 0, latched rd = 0, counters = 0; hence stall = 0, mul_busy = 0, flush_id = 0, pc_taken = 0, we_pc_ir = 1. Reset is effective mid-multiply and mid-BR_WAIT.

Configuration
REQ-019 Macro HAZ_PERF_CNT_EN, when defined:
- stall_cycles counts cycles with stall high.
- bubble_cycles counts cycles in BR_WAIT.
- Both are 32-bit and saturate at all-ones.
When undefined, both ports SHALL be driven 0 and no counter flops SHALL exist.

Structure
REQ-020 A shared package SHALL hold the FSM state encoding, the fwd select width constant (3) and the value FWD_RF = 0.
REQ-021 Forwarding match SHALL be a sub-module, fwd_sel, instantiated twice (A and B); the multiply scoreboard and the FSM stay in the top.

Verification
REQ-022 EX st_wreg[0]=1, st_rn[0]=8; MEM st_wreg[1]=1, st_rn[1]=8; id_rs=8, id_use_rs=1 -> fwd_a = 1 (nearest stage wins).
REQ-023 ex_m2reg=1, st_rn[0]=5, id_rt=5, id_use_rt=1 -> stall = 1 and we_pc_ir = 0 for one cycle, then fwd_b = 2 once the load is in MEM.
REQ-024 MUL_LAT=3, multiply to r9 issues, next instruction reads r9 -> stall = 1 for 2 cycles; a second multiply issuing in the cycle after mul_busy drops -> no stall.
REQ-025 beq issues; br_resolved=1, br_taken=1 three cycles later -> flush_id and we_pc_ir = 0 for those 3 cycles; pc_taken = 1 in the resolving cycle; then IDLE. With HAZ_PERF_CNT_EN: bubble_cycles = 3.
REQ-026 Reset asserted during BR_WAIT with mul_busy = 1 -> all outputs take their reset values immediately and asynchronously; id_rs = 0 with st_rn[0] = 0 -> fwd_a = 0.
